mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the pipelined datapath's instruction-fetch and data-memory requests onto a single-ported RAM. It sits directly downstream of the request unit. Per cycle it grants at most one requester, drives the RAM handshake, and returns wait/load results. Data requests have priority over fetches, bounded by an instruction anti-starvation counter. An optional one-entry fetch buffer can be compiled in.

## Interface
- STARVE_MAX, 4: consecutive data grants while a fetch is pending before the fetch is forced to win once.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- iREN  in  1  instruction read request; held until iwait low.
- iaddr  in  32  fetch address (word_t).
- iwait  out  1  fetch not complete this cycle.
- iload  out  32  fetched instruction; valid only in the cycle iwait is low.
- dREN, dWEN  in  1 each  data read/write request; never both high.
- daddr, dstore  in  32 each  data address and store value.
- dwait  out  1  data access not complete this cycle.
- dload  out  32  load result; valid only in the cycle dwait is low.
- ramREN, ramWEN  out  1 each  RAM read/write strobes.
- ramaddr, ramstore  out  32 each  RAM address and write data.
- ramload  in  32  RAM read data; valid when ramready is high.
- ramready  in  1  RAM completes the presented access this cycle.

## Operation
- States: IDLE, DATA, INSTR.
- IDLE: ram strobes low.
  - dREN|dWEN, and not forced-instruction: latch daddr/dstore/op, go DATA.
  - else iREN: latch iaddr, go INSTR.
- Forced-instruction: starve_cnt == STARVE_MAX and iREN high.
- starve_cnt (3 bits):
  - +1 on each DATA grant taken while iREN is high, saturating at STARVE_MAX.
  - Cleared on every INSTR grant.
- DATA:
  - Drive latched address/data and ramREN or ramWEN.
  - On ramready: dwait low for that cycle, dload = ramload (reads); next state IDLE.
  - A latched write completes even if dWEN drops mid-access; dwait is still low in the completion cycle.
  - A read whose dREN drops is abandoned: next state IDLE, no completion signalled.
- INSTR:
  - Drive latched iaddr with ramREN.
  - On ramready: iwait low, iload = ramload, next state IDLE.
  - If iREN drops, or iaddr differs from the latched address (redirect): abort to IDLE next cycle. A ramready in that same cycle is ignored.
- iwait = iREN && !fetch_done. dwait = (dREN|dWEN) && !data_done. Both are combinational.
- Idle requesters see wait low.

## Timing
- Request first seen in IDLE at cycle t: grant at t+1; completion in the first cycle ≥ t+1 with ramready high.
- Minimum access latency is 1 cycle after the request.
- One IDLE cycle always separates consecutive RAM transactions.
- Simultaneous new dREN and iREN in IDLE: data wins unless forced-instruction applies.
- RST in any state: next state IDLE, starve_cnt = 0, latches cleared, ram strobes low, fetch buffer invalid.
- Reset output values: ramREN = ramWEN = 0, ramaddr = ramstore = 0. iload and dload are 0 when not completing; iwait/dwait follow the request inputs.

## Configuration
- MEM_ARBITER_IBUF_EN defined: one-entry fetch buffer (valid, tag, data).
  - Filled on each INSTR completion.
  - In IDLE, iREN with valid && tag == iaddr: iwait low in that same cycle, iload = buffered data, no RAM access, state stays IDLE. This hit is taken only when no data request is pending.
  - Invalidated on RAM write completion with daddr == tag, and on RST.
- Undefined: every fetch goes to RAM; no buffer state exists.

## Test plan
- Single fetch: iREN, iaddr = 0x40, ramready one cycle after grant, ramload = 0x8C010004 -> iwait low exactly once, iload = 0x8C010004, ramREN high 2 cycles.
- Conflict: iREN and dREN together, daddr = 0x100 -> DATA serviced first, dload valid, then IDLE, then INSTR grant.
- Starvation: continuous dWEN with iREN held, STARVE_MAX = 4 -> after 4 data grants, the 5th grant is INSTR.
- Write hold: dWEN dropped one cycle after grant, ramready 3 cycles later -> ramWEN held until ramready, write completes with the latched dstore.
- Redirect: iaddr changes 0x40 -> 0x80 mid-INSTR -> abort to IDLE, new grant for 0x80, no iwait-low for 0x40.
- MEM_ARBITER_IBUF_EN: refetch 0x40 -> zero-wait hit, no ramREN; after a write to 0x40, the refetch goes to RAM.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction-fetch and data-memory requests onto a
// single-ported RAM. Data requests have priority; a saturating starvation
// counter forces one fetch through after STARVE_MAX data grants taken while a
// fetch was waiting.
// Optional feature macro: MEM_ARBITER_IBUF_EN compiles in a one-entry fetch
// buffer (valid, tag, data) that answers repeated fetches without the RAM.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  // instruction fetch port
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  // data port
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  // RAM port
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    INSTR = 2'd2
  } state_t;

  localparam logic [2:0] STARVE_LIMIT = 3'(STARVE_MAX);

  state_t      state_reg, state_next;
  logic [2:0]  starve_cnt_reg, starve_cnt_next;
  // address/data/op captured at grant time; the requester may change its
  // inputs afterwards (writes must still complete with the captured value)
  logic [31:0] addr_reg, addr_next;
  logic [31:0] store_reg, store_next;
  logic        wen_reg, wen_next;

  logic        data_req;
  logic        forced_instr;
  logic        fetch_done;
  logic        data_done;
  logic        ibuf_fill;      // INSTR completion: refresh the fetch buffer
  logic        wr_complete;    // RAM write finished at addr_reg
  logic        ibuf_hit;
  logic [31:0] ibuf_rdata;

  assign data_req     = dREN | dWEN;
  assign forced_instr = (starve_cnt_reg == STARVE_LIMIT) && iREN;

  // wait is simply "requesting and not finishing this cycle", so an idle
  // requester always sees wait low
  assign iwait = iREN && !fetch_done;
  assign dwait = data_req && !data_done;

`ifdef MEM_ARBITER_IBUF_EN
  logic        ibuf_valid_reg;
  logic [31:0] ibuf_tag_reg;
  logic [31:0] ibuf_data_reg;

  assign ibuf_hit   = ibuf_valid_reg && (ibuf_tag_reg == iaddr);
  assign ibuf_rdata = ibuf_data_reg;

  // fetch buffer: filled by every completed RAM fetch, dropped when a write
  // lands on the buffered address so stale instructions are never served
  always_ff @(posedge CLK) begin
    if (RST) begin
      ibuf_valid_reg <= 1'b0;
      ibuf_tag_reg   <= '0;
      ibuf_data_reg  <= '0;
    end else if (ibuf_fill) begin
      ibuf_valid_reg <= 1'b1;
      ibuf_tag_reg   <= addr_reg;
      ibuf_data_reg  <= ramload;
    end else if (wr_complete && (addr_reg == ibuf_tag_reg)) begin
      ibuf_valid_reg <= 1'b0;
    end
  end
`else
  // no buffer: every fetch goes to the RAM
  logic ibuf_unused;
  assign ibuf_hit    = 1'b0;
  assign ibuf_rdata  = '0;
  assign ibuf_unused = ibuf_fill ^ wr_complete;
`endif

  // state, starvation counter and request latches
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
      addr_reg       <= '0;
      store_reg      <= '0;
      wen_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      addr_reg       <= addr_next;
      store_reg      <= store_next;
      wen_reg        <= wen_next;
    end
  end

  // next-state, RAM handshake and completion decode
  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    addr_next       = addr_reg;
    store_next      = store_reg;
    wen_next        = wen_reg;
    ramREN          = 1'b0;
    ramWEN          = 1'b0;
    ramaddr         = '0;
    ramstore        = '0;
    fetch_done      = 1'b0;
    data_done       = 1'b0;
    iload           = '0;
    dload           = '0;
    ibuf_fill       = 1'b0;
    wr_complete     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (data_req && !forced_instr) begin
          state_next = DATA;
          addr_next  = daddr;
          store_next = dstore;
          wen_next   = dWEN;
          // count data grants that made a pending fetch wait
          if (iREN && (starve_cnt_reg != STARVE_LIMIT)) begin
            starve_cnt_next = starve_cnt_reg + 3'd1;
          end
        end else if (iREN) begin
          if (ibuf_hit && !data_req) begin
            // buffer hit: answered in this cycle, RAM untouched
            fetch_done = 1'b1;
            iload      = ibuf_rdata;
          end else begin
            state_next      = INSTR;
            addr_next       = iaddr;
            store_next      = '0;
            wen_next        = 1'b0;
            starve_cnt_next = '0;
          end
        end
      end

      DATA: begin
        ramaddr  = addr_reg;
        ramstore = store_reg;
        ramWEN   = wen_reg;
        ramREN   = !wen_reg;
        if (wen_reg) begin
          // a granted write always runs to completion
          if (ramready) begin
            data_done   = 1'b1;
            wr_complete = 1'b1;
            state_next  = IDLE;
          end
        end else if (!dREN) begin
          // read withdrawn: abandon silently
          state_next = IDLE;
        end else if (ramready) begin
          data_done  = 1'b1;
          dload      = ramload;
          state_next = IDLE;
        end
      end

      INSTR: begin
        ramaddr = addr_reg;
        ramREN  = 1'b1;
        if (!iREN || (iaddr != addr_reg)) begin
          // fetch withdrawn or redirected: any ramready now belongs to the
          // stale address and is discarded
          state_next = IDLE;
        end else if (ramready) begin
          fetch_done = 1'b1;
          iload      = ramload;
          ibuf_fill  = 1'b1;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed cycle-by-cycle vectors for mem_arbiter with
// hand-computed expectations. Inputs change 1 time unit after the rising
// edge; outputs are compared 2 units later, mid-cycle.
// Covers the fetch-buffer behaviour when MEM_ARBITER_IBUF_EN is defined.
module tb_mem_arbiter;

  logic        CLK;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;

  int n_checks;
  int n_fail;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramready (ramready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    iREN     = 1'b0;
    iaddr    = '0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    ramload  = '0;
    ramready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST = 1'b1;
    clear_inputs();

    // ---------------- reset ----------------
    next_cycle();
    next_cycle();
    #2;
    check_value("rst_ramREN", 32'(ramREN), 32'd0);
    check_value("rst_ramWEN", 32'(ramWEN), 32'd0);
    check_value("rst_ramaddr", ramaddr, 32'd0);
    check_value("rst_ramstore", ramstore, 32'd0);
    check_value("rst_iwait", 32'(iwait), 32'd0);
    check_value("rst_dwait", 32'(dwait), 32'd0);
    check_value("rst_iload", iload, 32'd0);
    check_value("rst_dload", dload, 32'd0);
    next_cycle();
    RST = 1'b0;
    $display("txn reset done");

    // ---------------- single fetch 0x40 ----------------
    iREN = 1'b1; iaddr = 32'h40;
    #2;
    check_value("f1_idle_iwait", 32'(iwait), 32'd1);
    check_value("f1_idle_ramREN", 32'(ramREN), 32'd0);
    next_cycle();
    #2;
    check_value("f1_grant_ramREN", 32'(ramREN), 32'd1);
    check_value("f1_grant_ramaddr", ramaddr, 32'h40);
    check_value("f1_grant_iwait", 32'(iwait), 32'd1);
    next_cycle();
    ramready = 1'b1; ramload = 32'h8C010004;
    #2;
    check_value("f1_done_ramREN", 32'(ramREN), 32'd1);
    check_value("f1_done_iwait", 32'(iwait), 32'd0);
    check_value("f1_done_iload", iload, 32'h8C010004);
    next_cycle();
    clear_inputs();
    #2;
    check_value("f1_after_ramREN", 32'(ramREN), 32'd0);
    check_value("f1_after_iload", iload, 32'd0);
    $display("txn single fetch 0x40");
    next_cycle();

    // ---------------- conflict: data wins ----------------
    iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h100;
    #2;
    check_value("c_idle_dwait", 32'(dwait), 32'd1);
    check_value("c_idle_iwait", 32'(iwait), 32'd1);
    next_cycle();
    ramready = 1'b1; ramload = 32'hDEADBEEF;
    #2;
    check_value("c_data_ramREN", 32'(ramREN), 32'd1);
    check_value("c_data_ramaddr", ramaddr, 32'h100);
    check_value("c_data_dwait", 32'(dwait), 32'd0);
    check_value("c_data_dload", dload, 32'hDEADBEEF);
    check_value("c_data_iwait", 32'(iwait), 32'd1);
    next_cycle();
    dREN = 1'b0; daddr = '0; ramready = 1'b0; ramload = '0;
    #2;
    check_value("c_gap_ramREN", 32'(ramREN), 32'd0);
    next_cycle();
    ramready = 1'b1; ramload = 32'h12345678;
    #2;
    check_value("c_instr_ramaddr", ramaddr, 32'h44);
    check_value("c_instr_iwait", 32'(iwait), 32'd0);
    check_value("c_instr_iload", iload, 32'h12345678);
    next_cycle();
    clear_inputs();
    $display("txn conflict data 0x100 then fetch 0x44");
    next_cycle();

    // ---------------- starvation ----------------
    iREN = 1'b1; iaddr = 32'h48; dWEN = 1'b1; daddr = 32'h200; ramready = 1'b1;
    ramload = 32'h0BADF00D;
    for (int g = 0; g < 4; g++) begin
      dstore = 32'hA5A50000 + 32'(g);
      #2;
      check_value($sformatf("s_idle%0d_ramWEN", g), 32'(ramWEN), 32'd0);
      next_cycle();
      #2;
      check_value($sformatf("s_data%0d_ramWEN", g), 32'(ramWEN), 32'd1);
      check_value($sformatf("s_data%0d_ramstore", g), ramstore, 32'hA5A50000 + 32'(g));
      check_value($sformatf("s_data%0d_dwait", g), 32'(dwait), 32'd0);
      next_cycle();
    end
    #2;
    check_value("s_idle4_ramWEN", 32'(ramWEN), 32'd0);
    next_cycle();
    #2;
    check_value("s_grant5_ramREN", 32'(ramREN), 32'd1);
    check_value("s_grant5_ramWEN", 32'(ramWEN), 32'd0);
    check_value("s_grant5_ramaddr", ramaddr, 32'h48);
    check_value("s_grant5_iwait", 32'(iwait), 32'd0);
    check_value("s_grant5_dwait", 32'(dwait), 32'd1);
    next_cycle();
    clear_inputs();
    $display("txn starvation: 4 writes then fetch 0x48");
    next_cycle();

    // ---------------- write hold ----------------
    dWEN = 1'b1; daddr = 32'h300; dstore = 32'hCAFEF00D;
    next_cycle();
    #2;
    check_value("w_grant_ramWEN", 32'(ramWEN), 32'd1);
    check_value("w_grant_dwait", 32'(dwait), 32'd1);
    next_cycle();
    dWEN = 1'b0; daddr = '0; dstore = '0;
    for (int k = 0; k < 2; k++) begin
      #2;
      check_value($sformatf("w_hold%0d_ramWEN", k), 32'(ramWEN), 32'd1);
      check_value($sformatf("w_hold%0d_ramstore", k), ramstore, 32'hCAFEF00D);
      check_value($sformatf("w_hold%0d_ramaddr", k), ramaddr, 32'h300);
      next_cycle();
    end
    ramready = 1'b1;
    #2;
    check_value("w_done_ramWEN", 32'(ramWEN), 32'd1);
    check_value("w_done_dwait", 32'(dwait), 32'd0);
    next_cycle();
    ramready = 1'b0;
    #2;
    check_value("w_after_ramWEN", 32'(ramWEN), 32'd0);
    $display("txn write hold 0x300");
    next_cycle();

    // ---------------- abandoned read ----------------
    dREN = 1'b1; daddr = 32'h400;
    next_cycle();
    #2;
    check_value("ab_grant_ramREN", 32'(ramREN), 32'd1);
    next_cycle();
    dREN = 1'b0; ramready = 1'b1; ramload = 32'h11111111;
    #2;
    check_value("ab_drop_dload", dload, 32'd0);
    check_value("ab_drop_dwait", 32'(dwait), 32'd0);
    next_cycle();
    clear_inputs();
    #2;
    check_value("ab_after_ramREN", 32'(ramREN), 32'd0);
    $display("txn abandoned read 0x400");
    next_cycle();

    // ---------------- redirect ----------------
    iREN = 1'b1; iaddr = 32'h40;
    next_cycle();
    #2;
    check_value("r_grant_ramaddr", ramaddr, 32'h40);
    next_cycle();
    iaddr = 32'h80; ramready = 1'b1; ramload = 32'h99999999;
    #2;
    check_value("r_abort_iwait", 32'(iwait), 32'd1);
    check_value("r_abort_iload", iload, 32'd0);
    next_cycle();
    ramready = 1'b0; ramload = '0;
    #2;
    check_value("r_idle_ramREN", 32'(ramREN), 32'd0);
    check_value("r_idle_iwait", 32'(iwait), 32'd1);
    next_cycle();
    ramready = 1'b1; ramload = 32'h80808080;
    #2;
    check_value("r_new_ramaddr", ramaddr, 32'h80);
    check_value("r_new_iwait", 32'(iwait), 32'd0);
    check_value("r_new_iload", iload, 32'h80808080);
    next_cycle();
    clear_inputs();
    $display("txn redirect 0x40 -> 0x80");
    next_cycle();

    // ---------------- refetch / fetch buffer ----------------
    iREN = 1'b1; iaddr = 32'h40;
    next_cycle();
    ramready = 1'b1; ramload = 32'h8C010004;
    #2;
    check_value("b_fill_iload", iload, 32'h8C010004);
    next_cycle();
    clear_inputs();
    next_cycle();
    iREN = 1'b1; iaddr = 32'h40;
    #2;
`ifdef MEM_ARBITER_IBUF_EN
    check_value("b_hit_iwait", 32'(iwait), 32'd0);
    check_value("b_hit_iload", iload, 32'h8C010004);
    check_value("b_hit_ramREN", 32'(ramREN), 32'd0);
    next_cycle();
    iREN = 1'b0;
    #2;
    check_value("b_hit_after_ramREN", 32'(ramREN), 32'd0);
`else
    check_value("b_miss_iwait", 32'(iwait), 32'd1);
    next_cycle();
    ramready = 1'b1; ramload = 32'h8C010004;
    #2;
    check_value("b_miss_ramREN", 32'(ramREN), 32'd1);
    check_value("b_miss_iload", iload, 32'h8C010004);
`endif
    next_cycle();
    clear_inputs();
    next_cycle();
    // write 0x40, then the refetch must go to the RAM
    dWEN = 1'b1; daddr = 32'h40; dstore = 32'h77;
    next_cycle();
    ramready = 1'b1;
    #2;
    check_value("b_wr_ramaddr", ramaddr, 32'h40);
    check_value("b_wr_dwait", 32'(dwait), 32'd0);
    next_cycle();
    clear_inputs();
    iREN = 1'b1; iaddr = 32'h40;
    #2;
    check_value("b_refetch_iwait", 32'(iwait), 32'd1);
    check_value("b_refetch_idle_ramREN", 32'(ramREN), 32'd0);
    next_cycle();
    ramready = 1'b1; ramload = 32'h77;
    #2;
    check_value("b_refetch_ramREN", 32'(ramREN), 32'd1);
    check_value("b_refetch_iload", iload, 32'h77);
    next_cycle();
    clear_inputs();
    $display("txn refetch 0x40 around write");
    next_cycle();

    // ---------------- reset mid-fetch ----------------
    iREN = 1'b1; iaddr = 32'h500;
    next_cycle();
    RST = 1'b1;
    #2;
    check_value("rm_busy_ramREN", 32'(ramREN), 32'd1);
    next_cycle();
    RST = 1'b0; iREN = 1'b0; iaddr = '0;
    #2;
    check_value("rm_after_ramREN", 32'(ramREN), 32'd0);
    check_value("rm_after_ramaddr", ramaddr, 32'd0);
    $display("txn reset during fetch 0x500");
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
